// File: rtl/vector_act_requant.sv
// Streaming activation + requantisation stage for the fully-connected accumulator output.
// Stage 1 applies the per-beat activation; stage 2 rounds, shifts and saturates each lane.
module vector_act_requant #(
    parameter int unsigned IN_WIDTH   = 16,
    parameter int unsigned OUT_WIDTH  = 8,
    parameter int unsigned LANES      = 4,
    parameter int          THRESHOLD  = 0,
    parameter int unsigned LEAK_SHIFT = 3,
    parameter int          CLAMP_MAX  = 96,
    parameter int unsigned SHIFT      = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_mode,
    input  logic signed [IN_WIDTH-1:0]  in_data [LANES],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data [LANES],
    output logic                        out_sat,
    input  logic                        cnt_clr,
    output logic [CNT_WIDTH-1:0]        sat_count
);

    localparam int unsigned RW = IN_WIDTH + 1;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_RELU   = 2'd1;
    localparam logic [1:0] MODE_LEAKY  = 2'd2;

    localparam logic signed [IN_WIDTH-1:0] THR_C  = IN_WIDTH'(THRESHOLD);
    localparam logic signed [IN_WIDTH-1:0] CMAX_C = IN_WIDTH'(CLAMP_MAX);
    localparam logic signed [RW-1:0]       HALF_C = RW'((1 << SHIFT) >> 1);
    localparam logic signed [RW-1:0]       OMAX_C = RW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [RW-1:0]       OMIN_C = ~OMAX_C;

    logic                        s1_valid_q, s1_valid_d;
    logic signed [IN_WIDTH-1:0]  s1_data_q [LANES];
    logic signed [IN_WIDTH-1:0]  s1_data_d [LANES];
    logic                        s2_valid_q, s2_valid_d;
    logic signed [OUT_WIDTH-1:0] out_data_q [LANES];
    logic signed [OUT_WIDTH-1:0] out_data_d [LANES];
    logic                        out_sat_q, out_sat_d;
    logic [CNT_WIDTH-1:0]        sat_count_q, sat_count_d;
    logic                        s1_load, s2_load;

    function automatic logic signed [IN_WIDTH-1:0] activate(
        input logic [1:0]                 mode,
        input logic signed [IN_WIDTH-1:0] x
    );
        logic signed [IN_WIDTH-1:0] y;
        y = x;
        case (mode)
            MODE_BYPASS: y = x;
            MODE_RELU:   y = (x > THR_C) ? x : IN_WIDTH'(0);
            MODE_LEAKY:  y = (x > THR_C) ? x : (x >>> LEAK_SHIFT);
            default:     y = (x <= THR_C) ? IN_WIDTH'(0) : ((x > CMAX_C) ? CMAX_C : x);
        endcase
        return y;
    endfunction

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    s1_data_d[i] = activate(in_mode, in_data[i]);
                end
            end
        end
    end

    // Round-half-up shift in one extra bit of headroom, then clip to the output range.
    always_comb begin
        logic signed [RW-1:0] r;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        r          = '0;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_sat_d = 1'b0;
                for (int unsigned i = 0; i < LANES; i++) begin
                    r = ($signed({s1_data_q[i][IN_WIDTH-1], s1_data_q[i]}) + HALF_C) >>> SHIFT;
                    if (r > OMAX_C) begin
                        out_data_d[i] = OMAX_C[OUT_WIDTH-1:0];
                        out_sat_d     = 1'b1;
                    end else if (r < OMIN_C) begin
                        out_data_d[i] = OMIN_C[OUT_WIDTH-1:0];
                        out_sat_d     = 1'b1;
                    end else begin
                        out_data_d[i] = r[OUT_WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Saturating event counter; clear has priority over a same-cycle increment.
    always_comb begin
        sat_count_d = sat_count_q;
        if (cnt_clr) begin
            sat_count_d = '0;
        end else if (s2_valid_q && out_ready && out_sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '{default: '0};
            s2_valid_q  <= 1'b0;
            out_data_q  <= '{default: '0};
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s2_valid_q  <= s2_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_vector_act_requant.sv
// Directed bench for vector_act_requant: activation modes, backpressure, mid-stream reset
// and the saturating event counter (a second instance uses a 4-bit counter).
module tb_vector_act_requant;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic signed [15:0] in_data [4];
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data [4];
    logic              out_sat;
    logic              cnt_clr;
    logic [15:0]       sat_count;

    logic              c4_in_ready;
    logic              c4_out_valid;
    logic signed [7:0] c4_out_data [4];
    logic              c4_out_sat;
    logic [3:0]        c4_sat_count;

    int n_tests = 0;
    int n_fail  = 0;

    vector_act_requant dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .cnt_clr(cnt_clr), .sat_count(sat_count)
    );

    vector_act_requant #(.CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c4_in_ready),
        .in_mode(in_mode), .in_data(in_data), .out_valid(c4_out_valid),
        .out_ready(out_ready), .out_data(c4_out_data), .out_sat(c4_out_sat),
        .cnt_clr(cnt_clr), .sat_count(c4_sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated beat with out_ready=1: checks 2-cycle latency, lanes and out_sat.
    task automatic run_beat(input string tag, input logic [1:0] mode,
                            input int x0, input int x1, input int x2, input int x3,
                            input int e0, input int e1, input int e2, input int e3,
                            input logic esat);
        in_valid   = 1'b1;
        in_mode    = mode;
        in_data[0] = 16'(x0);
        in_data[1] = 16'(x1);
        in_data[2] = 16'(x2);
        in_data[3] = 16'(x3);
        step();
        in_valid = 1'b0;
        check({tag, "_early"}, out_valid, 0);
        step();
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_l0"}, out_data[0], e0);
        check({tag, "_l1"}, out_data[1], e1);
        check({tag, "_l2"}, out_data[2], e2);
        check({tag, "_l3"}, out_data[3], e3);
        check({tag, "_sat"}, out_sat, esat);
        step();
    endtask

    initial begin
        int sent;
        int rcv;
        int cyc;
        logic saw_stall;
        logic have_hold;
        logic [31:0] hold;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_data   = '{default: '0};
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_out_data", {out_data[3], out_data[2], out_data[1], out_data[0]}, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        run_beat("relu", 2'd1, -100, 0, 40, 1000, 0, 0, 10, 127, 1'b1);
        check("relu_count", sat_count, 1);
        check("relu_count_c4", c4_sat_count, 1);
        run_beat("leaky", 2'd2, -64, -1000, 7, -1, -2, -31, 2, 0, 1'b0);
        run_beat("clamp", 2'd3, 200, 96, 0, -5, 24, 24, 0, 0, 1'b0);
        check("clamp_count", sat_count, 1);

        // Back-to-back beats, modes 1, 3, 2, same lanes {-16, 200, 5, -1000}.
        in_data[0] = -16'sd16;
        in_data[1] = 16'sd200;
        in_data[2] = 16'sd5;
        in_data[3] = -16'sd1000;
        in_valid = 1'b1;
        in_mode  = 2'd1;
        step();
        in_mode = 2'd3;
        step();
        check("msw1_valid", out_valid, 1);
        check("msw1", {out_data[3], out_data[2], out_data[1], out_data[0]},
              {8'sd0, 8'sd1, 8'sd50, 8'sd0});
        in_mode = 2'd2;
        step();
        in_valid = 1'b0;
        check("msw3_valid", out_valid, 1);
        check("msw3", {out_data[3], out_data[2], out_data[1], out_data[0]},
              {8'sd0, 8'sd1, 8'sd24, 8'sd0});
        step();
        check("msw2_valid", out_valid, 1);
        check("msw2", {out_data[3], out_data[2], out_data[1], out_data[0]},
              {-8'sd31, 8'sd1, 8'sd50, 8'sd0});
        step();
        check("msw_drain", out_valid, 0);

        // Backpressure: out_ready low 3 cycles, high 1; beat k lane j carries 10k+j.
        sent = 0;
        rcv = 0;
        cyc = 0;
        saw_stall = 1'b0;
        have_hold = 1'b0;
        hold = '0;
        while (rcv < 10 && cyc < 200) begin
            out_ready = ((cyc % 4) == 3);
            in_valid  = (sent < 10);
            in_mode   = 2'd0;
            for (int j = 0; j < 4; j++) in_data[j] = 16'(4 * (10 * sent + j));
            #1;
            if (have_hold && out_valid)
                check("bp_stable", {out_data[3], out_data[2], out_data[1], out_data[0]}, hold);
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                for (int j = 0; j < 4; j++) check("bp_lane", out_data[j], 10 * rcv + j);
                rcv++;
                have_hold = 1'b0;
            end else if (out_valid) begin
                hold = {out_data[3], out_data[2], out_data[1], out_data[0]};
                have_hold = 1'b1;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_received", rcv, 10);
        check("bp_in_ready_low", saw_stall, 1);
        out_ready = 1'b1;
        step();
        step();
        check("bp_no_dup", out_valid, 0);

        // Reset with both stages full.
        out_ready  = 1'b0;
        in_mode    = 2'd0;
        in_data[0] = 16'sd40;
        in_valid   = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        check("mrst_full_valid", out_valid, 1);
        check("mrst_full_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        check("mrst_async_valid", out_valid, 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("mrst_in_ready", in_ready, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("mrst_no_stale", out_valid, 0);
        end
        check("mrst_count_c4", c4_sat_count, 0);

        // 17 saturating beats: 16-bit counter reaches 17, 4-bit counter holds at 15.
        in_data[0] = 16'sd1000;
        in_data[1] = 16'sd0;
        in_data[2] = 16'sd0;
        in_data[3] = 16'sd0;
        in_valid   = 1'b1;
        for (int k = 0; k < 17; k++) step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("cnt17_wide", sat_count, 17);
        check("cnt17_c4_hold", c4_sat_count, 15);

        // Clear coinciding with a saturating output transfer.
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("clr_valid", out_valid, 1);
        check("clr_sat", out_sat, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_wide", sat_count, 0);
        check("clr_c4", c4_sat_count, 0);
        check("clr_drained", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
